// File: rtl/pll_sup_pkg.sv
// Shared types and default constants for the PLL lock supervisor.
// Defaults assume a 27 MHz reference clock and a PLL toggle of fout/64.
package pll_sup_pkg;

  // Supervisor state encoding
  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    CHECK     = 3'd3,
    RUN       = 3'd4
  } pll_state_t;

  // Default timing constants in reference-clock cycles
  localparam int DEF_STABLE_CYCLES  = 2700;    // 100 us of solid lock
  localparam int DEF_WINDOW         = 27000;   // 1 ms measurement window
  localparam int DEF_LOCK_TIMEOUT   = 270000;  // 10 ms to acquire lock
  localparam int DEF_PLL_RST_CYCLES = 27;      // 1 us PLL reset pulse

  // Accepted toggle edges per window (141.75 MHz / 64 gives about 2215)
  localparam int DEF_FMIN = 2150;
  localparam int DEF_FMAX = 2280;

  // Datapath widths
  localparam int EDGE_W  = 16;
  localparam int RETRY_W = 4;

  localparam logic [EDGE_W-1:0]  EDGE_SAT  = {EDGE_W{1'b1}};
  localparam logic [RETRY_W-1:0] RETRY_SAT = {RETRY_W{1'b1}};

  // Unsigned, inclusive range test for a completed window count
  function automatic logic freq_in_range(
    input logic [EDGE_W-1:0] count,
    input logic [EDGE_W-1:0] fmin,
    input logic [EDGE_W-1:0] fmax
  );
    return (count >= fmin) && (count <= fmax);
  endfunction

  // Largest of three constants, used to size the shared FSM timer
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_freq_meter.sv
// Free-running frequency meter: counts both edges of the synchronized PLL
// toggle over fixed windows of reference-clock cycles.
module pll_freq_meter
  import pll_sup_pkg::*;
#(
  parameter int WINDOW = DEF_WINDOW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pll_tog,
  output logic [EDGE_W-1:0] freq_count,
  output logic              freq_valid,
  output logic              win_start
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  // [0] and [1] form the synchronizer, [2] holds the previous synced value
  logic [2:0]        tog_sync_reg;
  logic [WIN_W-1:0]  win_cnt_reg;
  logic [EDGE_W-1:0] edge_cnt_reg;
  logic [EDGE_W-1:0] edge_cnt_next;
  logic [EDGE_W-1:0] freq_count_reg;
  logic              freq_valid_reg;
  logic              tog_edge;
  logic              win_wrap;

  assign tog_edge  = tog_sync_reg[2] ^ tog_sync_reg[1];
  assign win_wrap  = (win_cnt_reg == WIN_LAST);
  assign win_start = (win_cnt_reg == '0);

  // Edge counter value including this cycle's edge, held at saturation
  always_comb begin
    edge_cnt_next = edge_cnt_reg;
    if (tog_edge && (edge_cnt_reg != EDGE_SAT)) begin
      edge_cnt_next = edge_cnt_reg + 1'b1;
    end
  end

  // Bring the asynchronous toggle into the clk domain and keep one extra stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tog_sync_reg <= '0;
    end else begin
      tog_sync_reg <= {tog_sync_reg[1:0], pll_tog};
    end
  end

  // Window counter runs back-to-back windows from reset, independent of the FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_cnt_reg <= '0;
    end else if (win_wrap) begin
      win_cnt_reg <= '0;
    end else begin
      win_cnt_reg <= win_cnt_reg + 1'b1;
    end
  end

  // Edge accumulation; the closing window captures an edge on its last cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cnt_reg   <= '0;
      freq_count_reg <= '0;
      freq_valid_reg <= 1'b0;
    end else begin
      freq_valid_reg <= win_wrap;
      if (win_wrap) begin
        freq_count_reg <= edge_cnt_next;
        edge_cnt_reg   <= '0;
      end else begin
        edge_cnt_reg   <= edge_cnt_next;
      end
    end
  end

  assign freq_count = freq_count_reg;
  assign freq_valid = freq_valid_reg;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences PLL resets, qualifies lock and output
// frequency, and releases the system reset only while the PLL is healthy.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int WINDOW         = DEF_WINDOW,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int FMIN           = DEF_FMIN,
  parameter int FMAX           = DEF_FMAX
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pll_lock,
  input  logic               pll_tog,
  output logic               pll_reset,
  output logic               sys_reset_n,
  output logic               pll_ok,
  output logic [EDGE_W-1:0]  freq_count,
  output logic               freq_valid,
  output logic [RETRY_W-1:0] retries
);

  // One timer is shared by RESET_PLL, WAIT_LOCK and STABLE
  localparam int TIMER_MAX = max3(STABLE_CYCLES, LOCK_TIMEOUT, PLL_RST_CYCLES);
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(PLL_RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);

  localparam logic [EDGE_W-1:0] FMIN_C = EDGE_W'(FMIN);
  localparam logic [EDGE_W-1:0] FMAX_C = EDGE_W'(FMAX);

  pll_state_t         state_reg;
  logic [TIMER_W-1:0] timer_reg;
  logic [RETRY_W-1:0] retries_reg;
  logic [RETRY_W-1:0] retries_next;
  logic [1:0]         lock_sync_reg;
  logic               pll_reset_reg;
  logic               sys_reset_n_reg;
  logic               pll_ok_reg;
  logic               seen_start_reg;
  logic               lock_ok;
  logic               count_ok;
  logic               win_start;

  assign lock_ok      = lock_sync_reg[1];
  assign count_ok     = freq_in_range(freq_count, FMIN_C, FMAX_C);
  assign retries_next = (retries_reg == RETRY_SAT) ? retries_reg : retries_reg + 1'b1;

  pll_freq_meter #(
    .WINDOW (WINDOW)
  ) u_meter (
    .clk        (clk),
    .reset_n    (reset_n),
    .pll_tog    (pll_tog),
    .freq_count (freq_count),
    .freq_valid (freq_valid),
    .win_start  (win_start)
  );

  // Two-flop synchronizer for the asynchronous lock indicator
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_sync_reg <= 2'b00;
    end else begin
      lock_sync_reg <= {lock_sync_reg[0], pll_lock};
    end
  end

  // Supervisor FSM with timers, retry counter and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= RESET_PLL;
      timer_reg       <= '0;
      retries_reg     <= '0;
      pll_reset_reg   <= 1'b1;
      sys_reset_n_reg <= 1'b0;
      pll_ok_reg      <= 1'b0;
      seen_start_reg  <= 1'b0;
    end else begin
      case (state_reg)
        RESET_PLL: begin
          if (timer_reg == RST_LAST) begin
            state_reg     <= WAIT_LOCK;
            timer_reg     <= '0;
            pll_reset_reg <= 1'b0;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        WAIT_LOCK: begin
          if (lock_ok) begin
            state_reg <= STABLE;
            timer_reg <= '0;
          end else if (timer_reg == TIMEOUT_LAST) begin
            state_reg     <= RESET_PLL;
            timer_reg     <= '0;
            pll_reset_reg <= 1'b1;
            retries_reg   <= retries_next;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        STABLE: begin
          if (!lock_ok) begin
            // Any dropout restarts lock acquisition with a fresh timeout
            state_reg <= WAIT_LOCK;
            timer_reg <= '0;
          end else if (timer_reg == STABLE_LAST) begin
            state_reg      <= CHECK;
            timer_reg      <= '0;
            seen_start_reg <= 1'b0;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        CHECK: begin
          if (!lock_ok) begin
            state_reg     <= RESET_PLL;
            timer_reg     <= '0;
            pll_reset_reg <= 1'b1;
            retries_reg   <= retries_next;
          end else if (freq_valid && seen_start_reg) begin
            if (count_ok) begin
              state_reg       <= RUN;
              sys_reset_n_reg <= 1'b1;
              pll_ok_reg      <= 1'b1;
            end else begin
              state_reg     <= RESET_PLL;
              timer_reg     <= '0;
              pll_reset_reg <= 1'b1;
              retries_reg   <= retries_next;
            end
          end else if (win_start) begin
            // Windows already in flight at CHECK entry are ignored
            seen_start_reg <= 1'b1;
          end
        end

        RUN: begin
          if (!lock_ok || (freq_valid && !count_ok)) begin
            state_reg       <= RESET_PLL;
            timer_reg       <= '0;
            pll_reset_reg   <= 1'b1;
            sys_reset_n_reg <= 1'b0;
            pll_ok_reg      <= 1'b0;
            retries_reg     <= retries_next;
          end
        end

        default: begin
          state_reg       <= RESET_PLL;
          timer_reg       <= '0;
          pll_reset_reg   <= 1'b1;
          sys_reset_n_reg <= 1'b0;
          pll_ok_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign pll_reset   = pll_reset_reg;
  assign sys_reset_n = sys_reset_n_reg;
  assign pll_ok      = pll_ok_reg;
  assign retries     = retries_reg;

endmodule
